dds_sweep_ctrl: RTL and testbench

Frequency-sweep scheduler that drives the 16-bit `freq_control` word of the 125 MHz sine DDS phase accumulator. It steps the tuning word from a start value to a stop value in fixed increments, holding each point for a programmable dwell time. Three modes are supported: single-shot, repeat, and ping-pong. Configuration is loaded over a valid/ready handshake; the sweep is launched by `start` and can be cancelled by `abort`.

---
 rtl/dds_sweep_ctrl_pkg.sv | 22 ++
 rtl/dds_sweep_ctrl_if.sv | 36 +++
 rtl/dds_sweep_ctrl_dwell_timer.sv | 29 ++
 rtl/dds_sweep_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dds_sweep_ctrl_pkg.sv
// Shared constants and enumerations for the DDS frequency-sweep controller.
package dds_pkg;

  // Tuning-word width; matches the DDS freq_control input.
  localparam int FREQ_W  = 16;
  // Dwell counter width; about 134 ms at 125 MHz.
  localparam int DWELL_W = 24;

  // Encoding 3 is reserved and behaves as MODE_SINGLE.
  typedef enum logic [1:0] {
    MODE_SINGLE   = 2'd0,
    MODE_REPEAT   = 2'd1,
    MODE_PINGPONG = 2'd2
  } sweep_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } sweep_state_t;

endpackage

// File: rtl/dds_sweep_ctrl_if.sv
// Configuration handshake bundle for the sweep controller.
// The master offers a complete sweep description; the slave accepts it on valid & ready.
interface dds_sweep_ctrl_if #(
  parameter int FREQ_W  = dds_pkg::FREQ_W,
  parameter int DWELL_W = dds_pkg::DWELL_W
);

  logic               cfg_valid;
  logic               cfg_ready;
  logic [FREQ_W-1:0]  cfg_start_freq;
  logic [FREQ_W-1:0]  cfg_stop_freq;
  logic [FREQ_W-1:0]  cfg_step;
  logic [DWELL_W-1:0] cfg_dwell;
  logic [1:0]         cfg_mode;

  modport master (
    output cfg_valid,
    output cfg_start_freq,
    output cfg_stop_freq,
    output cfg_step,
    output cfg_dwell,
    output cfg_mode,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_start_freq,
    input  cfg_stop_freq,
    input  cfg_step,
    input  cfg_dwell,
    input  cfg_mode,
    output cfg_ready
  );

endinterface

// File: rtl/dds_sweep_ctrl_dwell_timer.sv
// Generic dwell down-counter. Load the hold length minus one; expire is high on the
// last cycle of the hold (terminal count zero) while the timer is enabled.
module dwell_timer #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt_q;

  // Reload on every new point, otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign expire = en && (cnt_q == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep scheduler for the sine DDS tuning word.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | not sweeping; accepts config, waits for start
//   UP    | stepping the tuning word upward (also used for repeat and
//         | single-point sweeps)
//   DOWN  | ping-pong return leg, stepping downward toward start
//
// A sweep runs from a private copy of the configuration taken at launch, so a
// config accepted in the same cycle as start only affects the next sweep.
module dds_sweep_ctrl #(
  parameter int FREQ_W  = dds_pkg::FREQ_W,
  parameter int DWELL_W = dds_pkg::DWELL_W
) (
  input  logic                clk,
  input  logic                rst_n,
  dds_sweep_ctrl_if.slave     cfg,
  input  logic                start,
  input  logic                abort,
  output logic [FREQ_W-1:0]   freq_control,
  output logic                freq_valid,
  output logic                busy,
  output logic                done,
  output logic                sweep_dir
);

  import dds_pkg::*;

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] UP   = ST_UP;
  localparam logic [1:0] DOWN = ST_DOWN;

  logic [1:0]         state_q;

  logic [FREQ_W-1:0]  cfg_start_q;
  logic [FREQ_W-1:0]  cfg_stop_q;
  logic [FREQ_W-1:0]  cfg_step_q;
  logic [DWELL_W-1:0] cfg_dwell_q;
  logic [1:0]         cfg_mode_q;
  logic               cfg_loaded_q;

  logic [FREQ_W-1:0]  run_start_q;
  logic [FREQ_W-1:0]  run_stop_q;
  logic [FREQ_W-1:0]  run_step_q;
  logic [DWELL_W-1:0] run_dwell_m1_q;
  logic [1:0]         run_mode_q;

  logic               cfg_fire;
  logic               launch;
  logic [FREQ_W-1:0]  launch_step;
  logic [DWELL_W-1:0] launch_dwell_m1;

  logic [FREQ_W:0]    up_sum;
  logic [FREQ_W:0]    dn_floor;
  logic [FREQ_W-1:0]  up_pt;
  logic [FREQ_W-1:0]  dn_pt;
  logic               degenerate;
  logic               at_stop;
  logic               mode_rep;
  logic               mode_pp;

  logic [1:0]         nxt_state;
  logic [FREQ_W-1:0]  nxt_freq;
  logic               nxt_dir;
  logic               emit;
  logic               finish;

  logic               tmr_load;
  logic [DWELL_W-1:0] tmr_load_val;
  logic               tmr_expire;

  assign cfg.cfg_ready = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign cfg_fire      = cfg.cfg_valid && cfg.cfg_ready;
  assign launch        = (state_q == IDLE) && start && cfg_loaded_q && !abort;

  // Zero step and zero dwell are promoted to one so a sweep always makes progress.
  assign launch_step     = (cfg_step_q == '0) ? FREQ_W'(1) : cfg_step_q;
  assign launch_dwell_m1 = (cfg_dwell_q == '0) ? '0 : cfg_dwell_q - DWELL_W'(1);

  // Step arithmetic is one bit wider so an upward carry clamps to stop instead of wrapping.
  assign up_sum     = {1'b0, freq_control} + {1'b0, run_step_q};
  assign up_pt      = (up_sum >= {1'b0, run_stop_q}) ? run_stop_q : up_sum[FREQ_W-1:0];
  assign dn_floor   = {1'b0, run_start_q} + {1'b0, run_step_q};
  assign dn_pt      = ({1'b0, freq_control} < dn_floor) ? run_start_q : freq_control - run_step_q;
  assign degenerate = (run_start_q >= run_stop_q);
  assign at_stop    = degenerate || (freq_control == run_stop_q);
  assign mode_rep   = (run_mode_q == MODE_REPEAT);
  assign mode_pp    = (run_mode_q == MODE_PINGPONG);

  // Next-point selection: advance only when the current point's dwell expires.
  always_comb begin
    nxt_state = state_q;
    nxt_freq  = freq_control;
    nxt_dir   = sweep_dir;
    emit      = 1'b0;
    finish    = 1'b0;
    case (state_q)
      UP: begin
        if (tmr_expire) begin
          if (!at_stop) begin
            nxt_freq = up_pt;
            emit     = 1'b1;
          end else if (mode_pp && !degenerate) begin
            nxt_state = DOWN;
            nxt_dir   = 1'b1;
            nxt_freq  = dn_pt;
            emit      = 1'b1;
          end else if (mode_pp || mode_rep) begin
            nxt_freq = run_start_q;
            emit     = 1'b1;
          end else begin
            nxt_state = IDLE;
            finish    = 1'b1;
          end
        end
      end
      DOWN: begin
        if (tmr_expire) begin
          if (freq_control == run_start_q) begin
            nxt_state = UP;
            nxt_dir   = 1'b0;
            nxt_freq  = up_pt;
          end else begin
            nxt_freq = dn_pt;
          end
          emit = 1'b1;
        end
      end
      default: begin
        if (launch) begin
          nxt_state = UP;
          nxt_dir   = 1'b0;
          nxt_freq  = cfg_start_q;
          emit      = 1'b1;
        end
      end
    endcase
  end

  assign tmr_load     = emit && !abort;
  assign tmr_load_val = launch ? launch_dwell_m1 : run_dwell_m1_q;

  dwell_timer #(.W(DWELL_W)) u_dwell_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .en       (busy),
    .load_val (tmr_load_val),
    .expire   (tmr_expire)
  );

  // Sweep state and DDS-facing outputs; abort overrides everything except reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      freq_control <= '0;
      freq_valid   <= 1'b0;
      done         <= 1'b0;
      sweep_dir    <= 1'b0;
    end else if (abort) begin
      state_q      <= IDLE;
      freq_control <= '0;
      freq_valid   <= 1'b0;
      done         <= 1'b0;
      sweep_dir    <= 1'b0;
    end else begin
      state_q      <= nxt_state;
      freq_control <= nxt_freq;
      freq_valid   <= emit;
      done         <= finish;
      sweep_dir    <= nxt_dir;
    end
  end

  // Latched configuration, written only through the IDLE handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_start_q  <= '0;
      cfg_stop_q   <= '0;
      cfg_step_q   <= '0;
      cfg_dwell_q  <= '0;
      cfg_mode_q   <= '0;
      cfg_loaded_q <= 1'b0;
    end else if (cfg_fire) begin
      cfg_start_q  <= cfg.cfg_start_freq;
      cfg_stop_q   <= cfg.cfg_stop_freq;
      cfg_step_q   <= cfg.cfg_step;
      cfg_dwell_q  <= cfg.cfg_dwell;
      cfg_mode_q   <= cfg.cfg_mode;
      cfg_loaded_q <= 1'b1;
    end
  end

  // Working copy of the configuration, frozen for the duration of a sweep.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_start_q    <= '0;
      run_stop_q     <= '0;
      run_step_q     <= '0;
      run_dwell_m1_q <= '0;
      run_mode_q     <= '0;
    end else if (launch) begin
      run_start_q    <= cfg_start_q;
      run_stop_q     <= cfg_stop_q;
      run_step_q     <= launch_step;
      run_dwell_m1_q <= launch_dwell_m1;
      run_mode_q     <= cfg_mode_q;
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl. A point-list model predicts every output
// on every cycle from the launch time, the dwell and the list of emitted points.
module tb_dds_sweep_ctrl;

  localparam int FW = 16;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [FW-1:0] freq_control;
  logic          freq_valid;
  logic          busy;
  logic          done;
  logic          sweep_dir;

  dds_sweep_ctrl_if #(.FREQ_W(FW), .DWELL_W(DW)) cfg_if ();

  dds_sweep_ctrl #(.FREQ_W(FW), .DWELL_W(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg          (cfg_if),
    .start        (start),
    .abort        (abort),
    .freq_control (freq_control),
    .freq_valid   (freq_valid),
    .busy         (busy),
    .done         (done),
    .sweep_dir    (sweep_dir)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  // Model state
  int  m_pts_f[$];
  bit  m_pts_d[$];
  bit  m_run = 1'b0;
  bit  m_single = 1'b0;
  int  m_L = 0;
  int  m_D = 1;
  int  m_n = 0;
  int  m_idle_freq = 0;
  bit  chk_en = 1'b0;

  int  done_cnt = 0;
  int  done_j = -1;

  // Build the expected sequence of points (value, direction) for one sweep.
  function automatic void gen(input int s, input int e, input int st_raw, input int mode, input int want);
    int st;
    int up[$];
    int dn[$];
    int v;
    bit single_mode;
    st = (st_raw == 0) ? 1 : st_raw;
    single_mode = (mode == 0) || (mode == 3);
    m_pts_f.delete();
    m_pts_d.delete();
    m_single = single_mode;
    if (s >= e) begin
      up.push_back(s);
    end else begin
      v = s;
      up.push_back(v);
      while (v < e) begin
        v = (v + st >= e) ? e : v + st;
        up.push_back(v);
      end
      v = e;
      dn.push_back(v);
      while (v > s) begin
        v = (v - st <= s) ? s : v - st;
        dn.push_back(v);
      end
    end
    foreach (up[i]) begin
      m_pts_f.push_back(up[i]);
      m_pts_d.push_back(1'b0);
    end
    m_n = up.size();
    if (!single_mode) begin
      while (m_pts_f.size() < want) begin
        if (mode == 2 && s < e) begin
          for (int i = 1; i < dn.size(); i++) begin
            m_pts_f.push_back(dn[i]);
            m_pts_d.push_back(1'b1);
          end
          for (int i = 1; i < up.size(); i++) begin
            m_pts_f.push_back(up[i]);
            m_pts_d.push_back(1'b0);
          end
        end else begin
          foreach (up[i]) begin
            m_pts_f.push_back(up[i]);
            m_pts_d.push_back(1'b0);
          end
        end
      end
    end
  endfunction

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic [31:0] ef;
    bit ev, eb, ed, edir;
    int j, idx;
    if (done === 1'b1) begin
      done_cnt++;
      done_j = cyc - m_L;
    end
    if (chk_en) begin
      ef = m_idle_freq; ev = 0; eb = 0; ed = 0; edir = 0;
      if (m_run) begin
        j = cyc - m_L;
        if (m_single && j >= m_n * m_D) begin
          ef = m_pts_f[m_n-1];
          ed = (j == m_n * m_D);
        end else begin
          idx = j / m_D;
          if (idx >= m_pts_f.size()) begin
            n_tests++;
            n_fail++;
            $display("FAIL model_range: point index %0d beyond %0d generated", idx, m_pts_f.size());
            idx = m_pts_f.size() - 1;
          end
          ef   = m_pts_f[idx];
          edir = m_pts_d[idx];
          ev   = ((j % m_D) == 0);
          eb   = 1'b1;
        end
      end
      check("freq_control", freq_control, ef);
      check("freq_valid", freq_valid, ev);
      check("busy", busy, eb);
      check("done", done, ed);
      check("sweep_dir", sweep_dir, edir);
      check("cfg_ready", cfg_if.cfg_ready, !eb);
    end
  end

  task automatic set_cfg(input int s, input int e, input int st, input int dw, input int md);
    cfg_if.cfg_start_freq = FW'(s);
    cfg_if.cfg_stop_freq  = FW'(e);
    cfg_if.cfg_step       = FW'(st);
    cfg_if.cfg_dwell      = DW'(dw);
    cfg_if.cfg_mode       = 2'(md);
  endtask

  task automatic load_cfg(input int s, input int e, input int st, input int dw, input int md);
    @(negedge clk);
    set_cfg(s, e, st, dw, md);
    cfg_if.cfg_valid = 1'b1;
    @(posedge clk);
    #1 cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic model_launch(input int s, input int e, input int st, input int dw, input int md, input int want);
    m_L = cyc;
    m_D = (dw == 0) ? 1 : dw;
    gen(s, e, st, md, want);
    m_run = 1'b1;
  endtask

  task automatic launch(input int s, input int e, input int st, input int dw, input int md, input int want);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    model_launch(s, e, st, dw, md, want);
  endtask

  task automatic do_abort();
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    m_run = 1'b0;
    m_idle_freq = 0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  int dc;

  initial begin
    cfg_if.cfg_valid = 1'b0;
    set_cfg(0, 0, 0, 0, 0);

    // Reset held for three edges with start asserted; start stays ignored afterwards.
    rst_n = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset_cfg_ready", cfg_if.cfg_ready, 1);
    check("reset_freq", freq_control, 0);
    wait_cycles(3);
    #1 start = 1'b0;
    check("start_without_cfg_busy", busy, 0);

    // Single sweep 100..130 step 10 dwell 4.
    load_cfg(100, 130, 10, 4, 0);
    dc = done_cnt;
    launch(100, 130, 10, 4, 0, 4);
    check("pin_single_n", m_n, 4);
    check("pin_single_p1", m_pts_f[1], 110);
    check("pin_single_p3", m_pts_f[3], 130);
    wait_cycles(20);
    check("single_done_count", done_cnt - dc, 1);
    check("single_done_time", done_j, 16);

    // Clamp at stop without landing on it.
    load_cfg(100, 125, 10, 1, 0);
    launch(100, 125, 10, 1, 0, 4);
    check("pin_clampA_p2", m_pts_f[2], 120);
    check("pin_clampA_p3", m_pts_f[3], 125);
    wait_cycles(6);

    // Carry-out of the step addition clamps to stop.
    load_cfg(16'hFFF0, 16'hFFFF, 16'h20, 2, 0);
    dc = done_cnt;
    launch(16'hFFF0, 16'hFFFF, 16'h20, 2, 0, 2);
    check("pin_clampB_n", m_n, 2);
    check("pin_clampB_p1", m_pts_f[1], 16'hFFFF);
    wait_cycles(7);
    check("clampB_done_count", done_cnt - dc, 1);
    check("clampB_done_time", done_j, 4);

    // Ping-pong 0..20 step 10 dwell 2.
    load_cfg(0, 20, 10, 2, 2);
    launch(0, 20, 10, 2, 2, 40);
    check("pin_pp_p3", m_pts_f[3], 10);
    check("pin_pp_d3", m_pts_d[3], 1);
    check("pin_pp_p4", m_pts_f[4], 0);
    check("pin_pp_p5", m_pts_f[5], 10);
    check("pin_pp_d5", m_pts_d[5], 0);
    check("pin_pp_p6", m_pts_f[6], 20);
    wait_cycles(30);
    do_abort();
    wait_cycles(2);

    // Repeat 5..7 step 1 dwell 1: done must never fire.
    load_cfg(5, 7, 1, 1, 1);
    dc = done_cnt;
    launch(5, 7, 1, 1, 1, 40);
    check("pin_rep_p3", m_pts_f[3], 5);
    check("pin_rep_p5", m_pts_f[5], 7);
    wait_cycles(20);
    do_abort();
    wait_cycles(2);
    check("repeat_no_done", done_cnt - dc, 0);

    // Abort during the third point.
    load_cfg(200, 300, 10, 3, 0);
    dc = done_cnt;
    launch(200, 300, 10, 3, 0, 11);
    wait_cycles(6);
    do_abort();
    check("abort_freq_zero", freq_control, 0);
    check("abort_busy", busy, 0);
    wait_cycles(3);
    check("abort_no_done", done_cnt - dc, 0);

    // Start and abort together: abort wins, no launch.
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", busy, 0);
    wait_cycles(3);

    // Config offered while busy is refused; a relaunch uses the old config.
    load_cfg(40, 60, 5, 2, 0);
    launch(40, 60, 5, 2, 0, 5);
    @(negedge clk);
    set_cfg(1000, 2000, 100, 7, 1);
    cfg_if.cfg_valid = 1'b1;
    repeat (4) @(negedge clk);
    check("busy_cfg_ready", cfg_if.cfg_ready, 0);
    cfg_if.cfg_valid = 1'b0;
    do_abort();
    wait_cycles(2);
    launch(40, 60, 5, 2, 0, 5);
    wait_cycles(13);

    // Config accepted in the launch cycle applies to the following sweep only.
    @(negedge clk);
    set_cfg(300, 303, 1, 1, 0);
    cfg_if.cfg_valid = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    model_launch(40, 60, 5, 2, 0, 5);
    wait_cycles(13);
    launch(300, 303, 1, 1, 0, 4);
    wait_cycles(6);

    // Degenerate range with zero step: one point, done after the dwell.
    load_cfg(50, 50, 0, 3, 0);
    launch(50, 50, 0, 3, 0, 1);
    check("pin_degen_n", m_n, 1);
    wait_cycles(5);
    check("degen_done_time", done_j, 3);

    // Reserved mode acts as single; zero dwell and zero step act as one.
    load_cfg(10, 12, 0, 0, 3);
    launch(10, 12, 0, 0, 3, 3);
    check("pin_rsv_p1", m_pts_f[1], 11);
    wait_cycles(5);
    check("rsv_done_time", done_j, 3);

    // Degenerate range in repeat mode re-emits start every dwell.
    load_cfg(80, 20, 5, 2, 1);
    launch(80, 20, 5, 2, 1, 20);
    wait_cycles(10);
    do_abort();
    wait_cycles(2);

    #1 chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
